vga_timing: RTL and testbench
=============================

# vga_timing

Generates 640x480@60 Hz VGA raster timing for the Pong top level. Free-running horizontal/vertical counters produce the `column`/`row` pixel coordinates consumed by the pixel renderer, plus `hsync`, `vsync`, a visible-area flag and a once-per-frame update strobe. The game datapath uses the strobe to move the paddles and ball during vertical blanking.

## Interface
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `clk`  input  1  pixel clock (25.175 MHz nominal); the only clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  pixel-advance enable. Tie high when `clk` is the pixel clock.
- `column`  output  10  horizontal counter, 0..H_TOTAL-1.
- `row`  output  10  vertical counter, 0..V_TOTAL-1.
- `hsync`  output  1  horizontal sync, active low.
- `vsync`  output  1  vertical sync, active low.
- `video_on`  output  1  high when (`column`,`row`) is in the visible area.
- `line_end`  output  1  one-`en`-cycle pulse on the last pixel of each line.
- `frame_tick`  output  1  one-`en`-cycle pulse at the first pixel of vertical blanking.

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 with defaults). V_TOTAL = sum of the V parameters (525 with defaults). Both must be ≤1024.
- All state and all outputs are registered. No output is combinational from inputs.
- Horizontal counter, on an `en` cycle:
  - `column`==H_TOTAL-1: wraps to 0.
  - otherwise: increments by 1.
- Vertical counter: advances only on an `en` cycle where `column`==H_TOTAL-1.
  - `row`==V_TOTAL-1: wraps to 0.
  - otherwise: increments by 1.
- `en` low: every register holds, including pulse outputs. A pulse therefore stretches while `en` is low.
- `hsync`=0 iff `column` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751].
- `vsync`=0 iff `row` is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490,491].
- `video_on`=1 iff `column`<H_VISIBLE and `row`<V_VISIBLE.
- `line_end`=1 iff `column`==H_TOTAL-1.
- `frame_tick`=1 iff `column`==0 and `row`==V_VISIBLE (480).
- `hsync`, `vsync`, `video_on`, `line_end` and `frame_tick` are decoded from the next-state counter values and registered. They are therefore cycle-aligned with the `column`/`row` they describe, with zero skew.
- The horizontal phase is tracked as the state sequence VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE. The vertical phase uses the same four states, stepped once per line.
- Counter arithmetic is unsigned 10-bit. Wrap is explicit at the TOTAL value; there is no reliance on natural 2^10 overflow.

## Timing
- Reset (asynchronous assert, synchronous release on the first `clk` edge after `rst_n` rises):
  - `column`=0, `row`=0
  - `hsync`=1, `vsync`=1
  - `video_on`=1, `line_end`=0, `frame_tick`=0
- First `en` cycle after reset release moves to `column`=1.
- Latency: every output changes on the same edge as the counter it describes.
- Line period: H_TOTAL `en` cycles. Frame period: H_TOTAL*V_TOTAL `en` cycles (420000 with defaults).
- Reset asserted mid-frame: returns immediately to the reset values. No partial sync pulse is completed.
- Frame wrap (`column`=799, `row`=524, `en`=1): next state is `column`=0, `row`=0, `video_on`=1, `line_end`=0. The same edge advances both counters.

## Test plan
- Reset, then `en`=1 for 800 cycles -> `column` steps 0..799 then 0; `row` goes 0 -> 1 on the wrap; `line_end` is high for exactly 1 cycle, at `column`=799.
- Over one line, probe hsync and video_on -> `hsync`=0 for exactly 96 cycles, `column` 656..751; `video_on` falls on the edge where `column` becomes 640.
- Full frame (420000 cycles) -> `vsync`=0 for exactly 1600 cycles (`row` 490..491); `frame_tick` pulses exactly once, at (0,480); `row` wraps 524 -> 0.
- `en` toggled 1-in-2, with `en` held low on `column`=799 -> counters advance only on `en` cycles; `line_end` stays high until the next `en` cycle; line period is 1600 `clk` cycles.
- Assert `rst_n`=0 asynchronously at (700,491) while `hsync`=0 and `vsync`=0 -> outputs immediately return to (0,0), `hsync`=1, `vsync`=1, `video_on`=1, without waiting for a clock edge.
- Check against an independent reference counter model for 2 full frames -> every output matches on every cycle.

Source files
------------

// File: rtl/vga_timing.sv
// 640x480@60 VGA raster timing: free-running column/row counters, syncs, visible flag and strobes.
// All outputs are registered from next-state decode, so they are zero-skew with column/row; en low freezes every register.
module vga_timing #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [9:0] column,
   output logic [9:0] row,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_end,
   output logic       frame_tick
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] C_H_FP_START = 10'(H_VISIBLE);
   localparam logic [9:0] C_H_SY_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] C_H_BP_START = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] C_V_FP_START = 10'(V_VISIBLE);
   localparam logic [9:0] C_V_SY_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] C_V_BP_START = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   typedef enum logic [1:0] {
      PH_VISIBLE,
      PH_FRONT,
      PH_SYNC,
      PH_BACK
   } phase_t;

   logic [9:0] r_col;
   logic [9:0] r_row;
   phase_t     r_hph;
   phase_t     r_vph;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_video_on;
   logic       r_line_end;
   logic       r_frame_tick;

   logic [9:0] w_col_nxt;
   logic [9:0] w_row_nxt;
   phase_t     w_hph_nxt;
   phase_t     w_vph_nxt;
   logic       w_line_wrap;
   logic       w_hsync_nxt;
   logic       w_vsync_nxt;
   logic       w_video_on_nxt;
   logic       w_line_end_nxt;
   logic       w_frame_tick_nxt;

   // Counter advance assuming an en cycle; the register stage gates on en.
   always_comb begin
      w_line_wrap = (r_col == C_H_LAST);
      w_col_nxt   = r_col + 10'd1;
      w_row_nxt   = r_row;
      if (w_line_wrap) begin
         w_col_nxt = '0;
         if (r_row == C_V_LAST) begin
            w_row_nxt = '0;
         end else begin
            w_row_nxt = r_row + 10'd1;
         end
      end
   end

   always_comb begin
      w_hph_nxt = r_hph;
      case (r_hph)
         PH_VISIBLE: if (w_col_nxt == C_H_FP_START) w_hph_nxt = PH_FRONT;
         PH_FRONT:   if (w_col_nxt == C_H_SY_START) w_hph_nxt = PH_SYNC;
         PH_SYNC:    if (w_col_nxt == C_H_BP_START) w_hph_nxt = PH_BACK;
         PH_BACK:    if (w_col_nxt == 10'd0)        w_hph_nxt = PH_VISIBLE;
         default:    w_hph_nxt = PH_VISIBLE;
      endcase
   end

   // Vertical phase steps once per line, on the horizontal wrap.
   always_comb begin
      w_vph_nxt = r_vph;
      if (w_line_wrap) begin
         case (r_vph)
            PH_VISIBLE: if (w_row_nxt == C_V_FP_START) w_vph_nxt = PH_FRONT;
            PH_FRONT:   if (w_row_nxt == C_V_SY_START) w_vph_nxt = PH_SYNC;
            PH_SYNC:    if (w_row_nxt == C_V_BP_START) w_vph_nxt = PH_BACK;
            PH_BACK:    if (w_row_nxt == 10'd0)        w_vph_nxt = PH_VISIBLE;
            default:    w_vph_nxt = PH_VISIBLE;
         endcase
      end
   end

   always_comb begin
      w_hsync_nxt      = (w_hph_nxt != PH_SYNC);
      w_vsync_nxt      = (w_vph_nxt != PH_SYNC);
      w_video_on_nxt   = (w_hph_nxt == PH_VISIBLE) && (w_vph_nxt == PH_VISIBLE);
      w_line_end_nxt   = (w_col_nxt == C_H_LAST);
      w_frame_tick_nxt = (w_col_nxt == 10'd0) && (w_row_nxt == C_V_FP_START);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col        <= '0;
         r_row        <= '0;
         r_hph        <= PH_VISIBLE;
         r_vph        <= PH_VISIBLE;
         r_hsync      <= 1'b1;
         r_vsync      <= 1'b1;
         r_video_on   <= 1'b1;
         r_line_end   <= 1'b0;
         r_frame_tick <= 1'b0;
      end else if (en) begin
         r_col        <= w_col_nxt;
         r_row        <= w_row_nxt;
         r_hph        <= w_hph_nxt;
         r_vph        <= w_vph_nxt;
         r_hsync      <= w_hsync_nxt;
         r_vsync      <= w_vsync_nxt;
         r_video_on   <= w_video_on_nxt;
         r_line_end   <= w_line_end_nxt;
         r_frame_tick <= w_frame_tick_nxt;
      end
   end

   assign column     = r_col;
   assign row        = r_row;
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign video_on   = r_video_on;
   assign line_end   = r_line_end;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default-size instance for line-level behaviour, reduced-size instance for frame-level behaviour.
module tb_vga_timing;

   logic       clk;
   logic       rst_n, en;
   logic [9:0] column, row;
   logic       hsync, vsync, video_on, line_end, frame_tick;

   logic       s_rst_n, s_en;
   logic [9:0] s_column, s_row;
   logic       s_hsync, s_vsync, s_video_on, s_line_end, s_frame_tick;

   int n_tests = 0;
   int n_fail  = 0;
   int m_col   = 0;
   int m_row   = 0;

   vga_timing u_dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .column(column), .row(row), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .line_end(line_end), .frame_tick(frame_tick)
   );

   // Small raster: H 8/2/3/2 (total 15), V 6/2/2/3 (total 13); frame = 195 cycles.
   vga_timing #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) u_small (
      .clk(clk), .rst_n(s_rst_n), .en(s_en),
      .column(s_column), .row(s_row), .hsync(s_hsync), .vsync(s_vsync),
      .video_on(s_video_on), .line_end(s_line_end), .frame_tick(s_frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_d(input string tag, input int c, input int r, input int hs, input int vs,
                        input int vo, input int le, input int ft);
      chk({tag, ".col"}, column, c);
      chk({tag, ".row"}, row, r);
      chk({tag, ".hsync"}, hsync, hs);
      chk({tag, ".vsync"}, vsync, vs);
      chk({tag, ".video_on"}, video_on, vo);
      chk({tag, ".line_end"}, line_end, le);
      chk({tag, ".frame_tick"}, frame_tick, ft);
   endtask

   task automatic chk_s(input string tag, input int c, input int r, input int hs, input int vs,
                        input int vo, input int le, input int ft);
      chk({tag, ".col"}, s_column, c);
      chk({tag, ".row"}, s_row, r);
      chk({tag, ".hsync"}, s_hsync, hs);
      chk({tag, ".vsync"}, s_vsync, vs);
      chk({tag, ".video_on"}, s_video_on, vo);
      chk({tag, ".line_end"}, s_line_end, le);
      chk({tag, ".frame_tick"}, s_frame_tick, ft);
   endtask

   task automatic model_step();
      if (m_col == 14) begin
         m_col = 0;
         m_row = (m_row == 12) ? 0 : m_row + 1;
      end else begin
         m_col = m_col + 1;
      end
   endtask

   task automatic chk_model(input string tag);
      chk_s(tag, m_col, m_row,
            (m_col >= 10 && m_col <= 12) ? 0 : 1,
            (m_row >= 8 && m_row <= 9) ? 0 : 1,
            (m_col < 8 && m_row < 6) ? 1 : 0,
            (m_col == 14) ? 1 : 0,
            (m_col == 0 && m_row == 6) ? 1 : 0);
   endtask

   initial begin
      int le_cnt, le_col, hs_cnt, hs_first, hs_last, vo_fall, ft_cnt, wrap_c;
      int guard, vs_cnt, wraps, prev_row;

      rst_n = 1'b1; en = 1'b0; s_rst_n = 1'b1; s_en = 1'b0;
      #2;
      rst_n = 1'b0; s_rst_n = 1'b0;
      #1;
      chk_d("rst_async", 0, 0, 1, 1, 1, 0, 0);
      chk_s("s_rst_async", 0, 0, 1, 1, 1, 0, 0);
      repeat (3) @(negedge clk);
      chk_d("rst_hold", 0, 0, 1, 1, 1, 0, 0);
      rst_n = 1'b1; s_rst_n = 1'b1; en = 1'b1;

      // One full line with en high.
      le_cnt = 0; le_col = -1; hs_cnt = 0; hs_first = -1; hs_last = -1; vo_fall = -1; ft_cnt = 0;
      for (int k = 1; k <= 800; k++) begin
         @(negedge clk);
         chk("sweep.col", column, k % 800);
         chk("sweep.row", row, k / 800);
         if (line_end) begin le_cnt++; le_col = int'(column); end
         if (!hsync) begin
            if (hs_cnt == 0) hs_first = int'(column);
            hs_last = int'(column);
            hs_cnt++;
         end
         if (!video_on && vo_fall < 0) vo_fall = int'(column);
         if (frame_tick) ft_cnt++;
      end
      chk("sweep.le_cnt", le_cnt, 1);
      chk("sweep.le_col", le_col, 799);
      chk("sweep.hs_cnt", hs_cnt, 96);
      chk("sweep.hs_first", hs_first, 656);
      chk("sweep.hs_last", hs_last, 751);
      chk("sweep.vo_fall", vo_fall, 640);
      chk("sweep.ft_cnt", ft_cnt, 0);
      chk_d("sweep.end", 0, 1, 1, 1, 1, 0, 0);
      chk_s("s_idle", 0, 0, 1, 1, 1, 0, 0);

      // en 1-in-2; en is low on every cycle following the arrival at column 799.
      le_cnt = 0; ft_cnt = 0; wrap_c = -1;
      for (int c = 0; c < 1600; c++) begin
         en = (c % 2 == 0);
         @(negedge clk);
         chk("en2.col", column, ((c / 2) + 1) % 800);
         chk("en2.row", row, 1 + ((c / 2) + 1) / 800);
         if (c == 1597) chk("en2.le_hold", line_end, 1);
         if (line_end) le_cnt++;
         if (frame_tick) ft_cnt++;
         if (column == 10'd0 && wrap_c < 0) wrap_c = c;
      end
      chk("en2.le_cnt", le_cnt, 2);
      chk("en2.wrap_c", wrap_c, 1598);
      chk("en2.ft_cnt", ft_cnt, 0);

      // Async reset in the middle of an hsync pulse.
      en = 1'b1;
      guard = 0;
      while (column != 10'd700 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      chk_d("d.at700", 700, 2, 0, 1, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_d("d.arst", 0, 0, 1, 1, 1, 0, 0);
      @(negedge clk);
      chk_d("d.arst_hold", 0, 0, 1, 1, 1, 0, 0);
      en = 1'b0;
      rst_n = 1'b1;

      // Two full small frames against the reference counter model.
      s_en = 1'b1;
      m_col = 0; m_row = 0;
      vs_cnt = 0; ft_cnt = 0; wraps = 0; prev_row = 0;
      for (int i = 0; i < 390; i++) begin
         @(negedge clk);
         model_step();
         chk_model("s.ref");
         if (!s_vsync && i < 195) vs_cnt++;
         if (s_frame_tick) ft_cnt++;
         if (prev_row == 12 && s_row == 10'd0) wraps++;
         prev_row = int'(s_row);
      end
      chk("s.vs_cnt", vs_cnt, 30);
      chk("s.ft_cnt", ft_cnt, 2);
      chk("s.wraps", wraps, 2);

      // Move into the hsync+vsync overlap, then reset asynchronously.
      guard = 0;
      while (!(m_col == 11 && m_row == 9) && guard < 400) begin
         @(negedge clk);
         model_step();
         chk_model("s.approach");
         guard++;
      end
      chk_s("s.pre_arst", 11, 9, 0, 0, 0, 0, 0);
      #2;
      s_rst_n = 1'b0;
      #1;
      chk_s("s.arst", 0, 0, 1, 1, 1, 0, 0);
      @(negedge clk);
      chk_s("s.arst_hold", 0, 0, 1, 1, 1, 0, 0);
      s_rst_n = 1'b1;
      m_col = 0; m_row = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         model_step();
         chk_model("s.post_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
